// File: rtl/pwm_pkg.sv
// Shared types and compare-pair arithmetic for pwmOC channel schedulers.
package pwm_pkg;

   localparam int PWM_WIDTH    = 17;
   localparam int PWM_HRBITS   = 3;
   localparam int PWM_DITHBITS = 4;

   // Smallest high/low time the OC block can express: one coarse tick.
   localparam logic [PWM_WIDTH:0] PWM_MINP = (PWM_WIDTH+1)'(1 << PWM_HRBITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      PEND = 2'd2
   } sched_state_t;

   // zero/full flag the two degenerate waveforms; cmp_l is valid otherwise.
   typedef struct packed {
      logic                 zero;
      logic                 full;
      logic                 sat;
      logic [PWM_WIDTH-1:0] cmp_l;
   } cmp_calc_t;

   // Clamp the duty into the expressible range and place the falling edge.
   // The phase is guaranteed below the period length, so a single
   // compare-subtract is enough to fold the falling edge back into range.
   function automatic cmp_calc_t pwm_cmp_calc(
      input logic [PWM_WIDTH-1:0] phase,
      input logic [PWM_WIDTH:0]   duty_c,
      input logic [PWM_WIDTH:0]   full
   );
      cmp_calc_t          res;
      logic [PWM_WIDTH:0] d;
      logic [PWM_WIDTH:0] l;
      res = '0;
      d   = duty_c;
      l   = '0;
      if (d == '0) begin
         res.zero = 1'b1;
      end else if (d >= full) begin
         res.full = 1'b1;
      end else begin
         if (d < PWM_MINP) begin
            d       = PWM_MINP;
            res.sat = 1'b1;
         end else if (d > full - PWM_MINP) begin
            d       = full - PWM_MINP;
            res.sat = 1'b1;
         end
         l = {1'b0, phase} + d;
         if (l >= full) begin
            l = l - full;
         end
         res.cmp_l = l[PWM_WIDTH-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_dither_acc.sv
// Fractional duty accumulator: the carry out adds one fine step to the
// duty of the period being prepared; the sum is committed on apply.
module pwm_dither_acc #(
   parameter int DITHBITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DITHBITS-1:0] frac,
   input  logic                load,
   output logic                carry
);

   logic [DITHBITS-1:0] acc_q;
   logic [DITHBITS-1:0] acc_d;
   logic [DITHBITS:0]   sum;

   // Sum and next accumulator value; only an apply advances the phase.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, frac};
      acc_d = load ? sum[DITHBITS-1:0] : acc_q;
   end

   assign carry = sum[DITHBITS];

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/pwm_oc_sched.sv
// Timebase and compare-pair scheduler for one pwmOC channel. Host updates
// are latched into a shadow slot, converted to a compare pair, and swapped
// into the active pair only on the period wrap so no period is ever torn.
module pwm_oc_sched
   import pwm_pkg::*;
#(
   parameter int WIDTH      = PWM_WIDTH,
   parameter int HRBITS     = PWM_HRBITS,
   parameter int DITHBITS   = PWM_DITHBITS,
   parameter int PERIOD_RST = 99
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [WIDTH-HRBITS-1:0]  upd_period,
   input  logic [WIDTH-1:0]         upd_phase,
   input  logic [WIDTH-1:0]         upd_duty,
   input  logic [DITHBITS-1:0]      upd_frac,
   output logic [WIDTH-HRBITS-1:0]  tb,
   output logic [WIDTH-1:0]         cmpH,
   output logic [WIDTH-1:0]         cmpL,
   output logic                     wrap,
   output logic                     sat
);

   localparam int CW = WIDTH - HRBITS;

   sched_state_t      state_q, state_d;
   logic [CW-1:0]     tb_q, tb_d;
   logic [CW-1:0]     period_q, period_d;
   logic              wrap_q, wrap_d;
   logic              run_q, run_d;
   logic [WIDTH-1:0]  cmph_q, cmph_d;
   logic [WIDTH-1:0]  cmpl_q, cmpl_d;
   logic              sat_q, sat_d;

   logic [CW-1:0]       sh_period_q, sh_period_d;
   logic [WIDTH-1:0]    sh_phase_q, sh_phase_d;
   logic [WIDTH-1:0]    sh_duty_q, sh_duty_d;
   logic [DITHBITS-1:0] sh_frac_q, sh_frac_d;

   logic [WIDTH-1:0]  pd_h_q, pd_h_d;
   logic [WIDTH-1:0]  pd_l_q, pd_l_d;
   logic              pd_sat_q, pd_sat_d;

   logic              apply;
   logic              carry;
   logic [WIDTH:0]    full_w;
   logic [WIDTH:0]    duty_c;
   cmp_calc_t         calc;

   pwm_dither_acc #(
      .DITHBITS (DITHBITS)
   ) u_dither (
      .clk   (clk),
      .rst_n (rst_n),
      .frac  (sh_frac_q),
      .load  (apply),
      .carry (carry)
   );

   // The period length used for clamping is that of the incoming update,
   // since the new pair will run inside the new period.
   assign full_w = (WIDTH+1)'({1'b0, sh_period_q} + (CW+1)'(1)) << HRBITS;
   assign duty_c = {1'b0, sh_duty_q} + (WIDTH+1)'(carry);
   assign calc   = pwm_cmp_calc(sh_phase_q, duty_c, full_w);

   // Timebase, handshake FSM and apply-at-wrap of the prepared compare pair.
   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      cmph_d      = cmph_q;
      cmpl_d      = cmpl_q;
      sat_d       = sat_q;
      sh_period_d = sh_period_q;
      sh_phase_d  = sh_phase_q;
      sh_duty_d   = sh_duty_q;
      sh_frac_d   = sh_frac_q;
      pd_h_d      = pd_h_q;
      pd_l_d      = pd_l_q;
      pd_sat_d    = pd_sat_q;
      run_d       = en;

      // Disabled channel has no period to wait for, so apply at once.
      apply = (state_q == PEND) && (wrap_q || !en);

      if (!en || (tb_q == period_q)) begin
         tb_d = '0;
      end else begin
         tb_d = tb_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (upd_valid) begin
               sh_period_d = upd_period;
               sh_phase_d  = upd_phase;
               sh_duty_d   = upd_duty;
               sh_frac_d   = upd_frac;
               state_d     = CALC;
            end
         end
         CALC: begin
            pd_h_d   = calc.zero ? '1 : sh_phase_q;
            pd_l_d   = calc.zero ? sh_phase_q : (calc.full ? '1 : calc.cmp_l);
            pd_sat_d = calc.sat;
            state_d  = PEND;
         end
         PEND: begin
            if (apply) begin
               cmph_d   = pd_h_q;
               cmpl_d   = pd_l_q;
               period_d = sh_period_q;
               sat_d    = pd_sat_q;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered so it lines up with tb showing the terminal count.
      wrap_d = en && (tb_d == period_d);
   end

   // State registers; reset also drops any update in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tb_q        <= '0;
         period_q    <= CW'(PERIOD_RST);
         wrap_q      <= 1'b0;
         run_q       <= 1'b0;
         cmph_q      <= '1;
         cmpl_q      <= '0;
         sat_q       <= 1'b0;
         sh_period_q <= '0;
         sh_phase_q  <= '0;
         sh_duty_q   <= '0;
         sh_frac_q   <= '0;
         pd_h_q      <= '0;
         pd_l_q      <= '0;
         pd_sat_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tb_q        <= tb_d;
         period_q    <= period_d;
         wrap_q      <= wrap_d;
         run_q       <= run_d;
         cmph_q      <= cmph_d;
         cmpl_q      <= cmpl_d;
         sat_q       <= sat_d;
         sh_period_q <= sh_period_d;
         sh_phase_q  <= sh_phase_d;
         sh_duty_q   <= sh_duty_d;
         sh_frac_q   <= sh_frac_d;
         pd_h_q      <= pd_h_d;
         pd_l_q      <= pd_l_d;
         pd_sat_q    <= pd_sat_d;
      end
   end

   // While stopped the compare pair is masked to "never rise", keeping the
   // active pair intact for when the channel is re-enabled.
   assign tb        = tb_q;
   assign wrap      = wrap_q;
   assign sat       = sat_q;
   assign upd_ready = (state_q == IDLE);
   assign cmpH      = run_q ? cmph_q : '1;
   assign cmpL      = run_q ? cmpl_q : '0;

endmodule

// File: tb/tb_pwm_oc_sched.sv
// Randomised and directed bench for pwm_oc_sched against a behavioural model.
module tb_pwm_oc_sched;

   localparam int WIDTH    = 17;
   localparam int HRBITS   = 3;
   localparam int DITHBITS = 4;
   localparam int CW       = WIDTH - HRBITS;
   localparam int ALL1     = 'h1FFFF;

   logic                clk;
   logic                rst_n;
   logic                en;
   logic                upd_valid;
   logic                upd_ready;
   logic [CW-1:0]       upd_period;
   logic [WIDTH-1:0]    upd_phase;
   logic [WIDTH-1:0]    upd_duty;
   logic [DITHBITS-1:0] upd_frac;
   logic [CW-1:0]       tb;
   logic [WIDTH-1:0]    cmpH;
   logic [WIDTH-1:0]    cmpL;
   logic                wrap;
   logic                sat;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: active values, timebase, and one pending update.
   int m_tb, m_period, m_cmph, m_cmpl, m_sat, m_acc, m_run, m_pend, m_age;
   int p_period, p_h, p_l, p_sat, p_acc;

   pwm_oc_sched #(
      .WIDTH(WIDTH), .HRBITS(HRBITS), .DITHBITS(DITHBITS), .PERIOD_RST(99)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_period(upd_period), .upd_phase(upd_phase),
      .upd_duty(upd_duty), .upd_frac(upd_frac),
      .tb(tb), .cmpH(cmpH), .cmpL(cmpL), .wrap(wrap), .sat(sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_h();
      return (m_run != 0) ? m_cmph : ALL1;
   endfunction

   function automatic int exp_l();
      return (m_run != 0) ? m_cmpl : 0;
   endfunction

   task automatic model_reset();
      m_tb = 0; m_period = 99; m_cmph = ALL1; m_cmpl = 0; m_sat = 0;
      m_acc = 0; m_run = 0; m_pend = 0; m_age = 0;
   endtask

   // Waveform the update describes, computed straight from the duty rules.
   task automatic model_calc(input int per, input int ph, input int du, input int fr);
      int full, s, d;
      full     = (per + 1) * 8;
      s        = m_acc + fr;
      p_acc    = s % 16;
      d        = du + s / 16;
      p_period = per;
      p_sat    = 0;
      if (d == 0) begin
         p_h = ALL1; p_l = ph;
      end else if (d >= full) begin
         p_h = ph; p_l = ALL1;
      end else begin
         if (d < 8) begin
            d = 8; p_sat = 1;
         end else if (d > full - 8) begin
            d = full - 8; p_sat = 1;
         end
         p_h = ph;
         p_l = (ph + d) % full;
      end
   endtask

   // One clock edge: an update becomes eligible two edges after capture and
   // is applied at the first terminal-count edge (or any disabled edge).
   task automatic tick();
      bit pre_wrap, do_apply, do_cap;
      @(posedge clk);
      pre_wrap = (m_tb == m_period);
      do_apply = (m_pend != 0) && (m_age >= 2) && (pre_wrap || !en);
      do_cap   = upd_valid && (m_pend == 0);
      if (!en || pre_wrap) m_tb = 0;
      else m_tb = m_tb + 1;
      if (do_apply) begin
         m_period = p_period; m_cmph = p_h; m_cmpl = p_l;
         m_sat = p_sat; m_acc = p_acc; m_pend = 0;
      end else if (m_pend != 0) begin
         m_age = m_age + 1;
      end
      if (do_cap) begin
         model_calc(int'(upd_period), int'(upd_phase), int'(upd_duty), int'(upd_frac));
         m_pend = 1; m_age = 1;
      end
      m_run = en ? 1 : 0;
      #1;
   endtask

   task automatic post(input int per, input int ph, input int du, input int fr);
      upd_period = CW'(per);
      upd_phase  = WIDTH'(ph);
      upd_duty   = WIDTH'(du);
      upd_frac   = DITHBITS'(fr);
      upd_valid  = 1'b1;
      tick();
      upd_valid  = 1'b0;
   endtask

   task automatic wait_apply(output int cycles, output bit timed_out);
      cycles = 0;
      while (m_pend != 0 && cycles < 1000) begin
         tick();
         cycles++;
      end
      timed_out = (m_pend != 0);
      $display("apply after %0d cycles: cmpH=%05h cmpL=%05h sat=%0b tb=%0d",
               cycles, cmpH, cmpL, sat, tb);
   endtask

   task automatic align(input int target, output bit timed_out);
      int n;
      n = 0;
      while (m_tb != target && n < 1000) begin
         tick();
         n++;
      end
      timed_out = (m_tb != target);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; upd_valid = 1'b0;
      upd_period = '0; upd_phase = '0; upd_duty = '0; upd_frac = '0;
      #12;
      n_checks += 6;
      if (tb !== '0) begin n_errors++; $display("FAIL reset_tb: got %0d expected 0", tb); end
      if (cmpH !== 17'h1FFFF) begin n_errors++; $display("FAIL reset_cmpH: got %05h expected 1ffff", cmpH); end
      if (cmpL !== '0) begin n_errors++; $display("FAIL reset_cmpL: got %05h expected 0", cmpL); end
      if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
      if (sat !== 1'b0) begin n_errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
      if (upd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", upd_ready); end
      rst_n = 1'b1;
      model_reset();
      $display("reset released");
   endtask

   task automatic test_timebase();
      int max_tb, n_wraps;
      max_tb = 0; n_wraps = 0;
      en = 1'b1;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (int'(tb) > max_tb) max_tb = int'(tb);
         if (wrap === 1'b1) n_wraps++;
         n_checks += 4;
         if (tb !== CW'(m_tb)) begin n_errors++; $display("FAIL tb_count: got %0d expected %0d", tb, m_tb); end
         if (wrap !== (m_tb == m_period)) begin n_errors++; $display("FAIL tb_wrap: got %b at tb=%0d", wrap, tb); end
         if (cmpH !== 17'h1FFFF) begin n_errors++; $display("FAIL tb_cmpH: got %05h expected 1ffff", cmpH); end
         if (cmpL !== '0) begin n_errors++; $display("FAIL tb_cmpL: got %05h expected 0", cmpL); end
      end
      n_checks += 2;
      if (max_tb != 99) begin n_errors++; $display("FAIL tb_max: got %0d expected 99", max_tb); end
      if (n_wraps != 2) begin n_errors++; $display("FAIL tb_nwraps: got %0d expected 2", n_wraps); end
      $display("timebase: max tb %0d, %0d wraps", max_tb, n_wraps);
   endtask

   task automatic test_directed();
      int t_ph[6]  = '{0,   700, 700, 700, 40,   40};
      int t_du[6]  = '{400, 200, 3,   797, 0,    800};
      int t_h[6]   = '{0,   700, 700, 700, ALL1, 40};
      int t_l[6]   = '{400, 100, 708, 692, 40,   ALL1};
      int t_s[6]   = '{0,   0,   1,   1,   0,    0};
      int cyc;
      bit to;
      for (int i = 0; i < 6; i++) begin
         post(99, t_ph[i], t_du[i], 0);
         n_checks++;
         if (upd_ready !== 1'b0) begin n_errors++; $display("FAIL dir_busy[%0d]: ready got %b expected 0", i, upd_ready); end
         wait_apply(cyc, to);
         n_checks += 6;
         if (to) begin n_errors++; $display("FAIL dir_timeout[%0d]: no apply in %0d cycles", i, cyc); end
         if (cmpH !== 17'(t_h[i])) begin n_errors++; $display("FAIL dir_cmpH[%0d]: got %05h expected %05h", i, cmpH, t_h[i]); end
         if (cmpL !== 17'(t_l[i])) begin n_errors++; $display("FAIL dir_cmpL[%0d]: got %05h expected %05h", i, cmpL, t_l[i]); end
         if (sat !== 1'(t_s[i])) begin n_errors++; $display("FAIL dir_sat[%0d]: got %b expected %0d", i, sat, t_s[i]); end
         if (upd_ready !== 1'b1) begin n_errors++; $display("FAIL dir_ready[%0d]: got %b expected 1", i, upd_ready); end
         if (tb !== '0) begin n_errors++; $display("FAIL dir_tb0[%0d]: got %0d expected 0", i, tb); end
      end
   endtask

   task automatic test_dither();
      int cyc, want;
      bit to;
      for (int i = 1; i <= 8; i++) begin
         post(99, 0, 400, 4);
         wait_apply(cyc, to);
         want = (i % 4 == 0) ? 401 : 400;
         n_checks += 4;
         if (to) begin n_errors++; $display("FAIL dith_timeout[%0d]: no apply", i); end
         if (cyc != 99) begin n_errors++; $display("FAIL dith_latency[%0d]: got %0d cycles expected 99", i, cyc); end
         if (cmpL !== 17'(want)) begin n_errors++; $display("FAIL dith_cmpL[%0d]: got %0d expected %0d", i, cmpL, want); end
         if (sat !== 1'b0) begin n_errors++; $display("FAIL dith_sat[%0d]: got %b expected 0", i, sat); end
      end
   endtask

   task automatic test_wrap_timing();
      int pre_tb[3] = '{99, 98, 97};
      int want[3]   = '{100, 101, 2};
      int cyc;
      bit to;
      for (int i = 0; i < 3; i++) begin
         align(pre_tb[i], to);
         n_checks++;
         if (to) begin n_errors++; $display("FAIL wt_align[%0d]: tb never reached %0d", i, pre_tb[i]); end
         post(99, 100 + i, 200, 0);
         wait_apply(cyc, to);
         n_checks += 3;
         if (to || cyc != want[i]) begin n_errors++; $display("FAIL wt_latency[%0d]: got %0d cycles expected %0d", i, cyc, want[i]); end
         if (cmpH !== 17'(100 + i)) begin n_errors++; $display("FAIL wt_cmpH[%0d]: got %0d expected %0d", i, cmpH, 100 + i); end
         if (cmpL !== 17'(300 + i)) begin n_errors++; $display("FAIL wt_cmpL[%0d]: got %0d expected %0d", i, cmpL, 300 + i); end
      end
   endtask

   task automatic test_en_drop();
      post(99, 123, 300, 0);
      tick();
      en = 1'b0;
      tick();
      n_checks += 5;
      if (m_pend != 0) begin n_errors++; $display("FAIL en_model: update still pending after disabled edge"); end
      if (upd_ready !== 1'b1) begin n_errors++; $display("FAIL en_ready: got %b expected 1", upd_ready); end
      if (cmpH !== 17'h1FFFF) begin n_errors++; $display("FAIL en_cmpH_off: got %05h expected 1ffff", cmpH); end
      if (tb !== '0) begin n_errors++; $display("FAIL en_tb: got %0d expected 0", tb); end
      if (wrap !== 1'b0) begin n_errors++; $display("FAIL en_wrap: got %b expected 0", wrap); end
      en = 1'b1;
      tick();
      n_checks += 2;
      if (cmpH !== 17'd123) begin n_errors++; $display("FAIL en_cmpH_on: got %0d expected 123", cmpH); end
      if (cmpL !== 17'd423) begin n_errors++; $display("FAIL en_cmpL_on: got %0d expected 423", cmpL); end
      $display("en drop: applied while disabled, cmpH=%0d cmpL=%0d", cmpH, cmpL);
   endtask

   task automatic test_reset_pend();
      int cyc;
      bit to;
      post(99, 0, 3, 0);
      wait_apply(cyc, to);
      n_checks++;
      if (sat !== 1'b1 || to) begin n_errors++; $display("FAIL rp_presat: got %b expected 1", sat); end
      post(99, 55, 200, 3);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks += 6;
      if (tb !== '0) begin n_errors++; $display("FAIL rp_tb: got %0d expected 0", tb); end
      if (cmpH !== 17'h1FFFF) begin n_errors++; $display("FAIL rp_cmpH: got %05h expected 1ffff", cmpH); end
      if (cmpL !== '0) begin n_errors++; $display("FAIL rp_cmpL: got %05h expected 0", cmpL); end
      if (sat !== 1'b0) begin n_errors++; $display("FAIL rp_sat: got %b expected 0", sat); end
      if (wrap !== 1'b0) begin n_errors++; $display("FAIL rp_wrap: got %b expected 0", wrap); end
      if (upd_ready !== 1'b1) begin n_errors++; $display("FAIL rp_ready: got %b expected 1", upd_ready); end
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 250; i++) tick();
      n_checks += 3;
      if (cmpH !== 17'h1FFFF) begin n_errors++; $display("FAIL rp_lost_cmpH: got %05h expected 1ffff", cmpH); end
      if (cmpL !== '0) begin n_errors++; $display("FAIL rp_lost_cmpL: got %05h expected 0", cmpL); end
      if (tb !== CW'(m_tb)) begin n_errors++; $display("FAIL rp_tb_after: got %0d expected %0d", tb, m_tb); end
      $display("reset while pending: update discarded");
   endtask

   task automatic test_random();
      int per, full, ph, du, fr, cyc;
      bit to;
      for (int i = 0; i < 40; i++) begin
         per  = $urandom_range(2, 40);
         full = (per + 1) * 8;
         ph   = $urandom_range(0, full - 1);
         case ($urandom_range(0, 5))
            0: du = 0;
            1: du = $urandom_range(1, 9);
            2: du = full - $urandom_range(0, 10);
            3: du = full + $urandom_range(0, 20);
            4: du = (($urandom_range(0, 1) != 0) ? 8 : full - 8);
            default: du = $urandom_range(0, full);
         endcase
         fr = $urandom_range(0, 15);
         for (int k = $urandom_range(0, per + 2); k > 0; k--) tick();
         post(per, ph, du, fr);
         if ($urandom_range(0, 4) == 0) begin
            tick();
            en = 1'b0;
            tick();
            en = 1'b1;
         end
         wait_apply(cyc, to);
         n_checks += 7;
         if (to) begin n_errors++; $display("FAIL rnd_timeout[%0d]: no apply", i); end
         if (cmpH !== 17'(exp_h())) begin n_errors++; $display("FAIL rnd_cmpH[%0d]: got %05h expected %05h", i, cmpH, exp_h()); end
         if (cmpL !== 17'(exp_l())) begin n_errors++; $display("FAIL rnd_cmpL[%0d]: got %05h expected %05h", i, cmpL, exp_l()); end
         if (sat !== 1'(m_sat)) begin n_errors++; $display("FAIL rnd_sat[%0d]: got %b expected %0d", i, sat, m_sat); end
         if (tb !== CW'(m_tb)) begin n_errors++; $display("FAIL rnd_tb[%0d]: got %0d expected %0d", i, tb, m_tb); end
         if (wrap !== (m_tb == m_period)) begin n_errors++; $display("FAIL rnd_wrap[%0d]: got %b", i, wrap); end
         if (upd_ready !== 1'b1) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected 1", i, upd_ready); end
         $display("rnd %0d: per=%0d ph=%0d duty=%0d frac=%0d", i, per, ph, du, fr);
      end
   endtask

   initial begin
      test_reset();
      test_timebase();
      test_directed();
      test_dither();
      test_wrap_timing();
      test_en_drop();
      test_reset_pend();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
